// File: rtl/deserializer_pkg.sv
// Shared types for the deserializer family (8-bit legacy block and deserializer_buf).
package deserializer_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RECEIVE = 2'd1,
    STALL   = 2'd2
  } state_t;

endpackage

// File: rtl/deser_shift_unit.sv
// Serial-in shift register with bit counter. Presents the word that would be
// formed if the current bit were accepted, plus a flag marking the last bit.
module deser_shift_unit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_100KHZ,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] sh_q,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  // Word including the bit on data_in; this is what a completing edge delivers.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {sh[WIDTH-2:0], data_in};
    end else begin : g_lsb
      assign word = {data_in, sh[WIDTH-1:1]};
    end
  endgenerate

  assign sh_q     = sh;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Shift one bit per accepted strobe; counter wraps after the last bit.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sh  <= word;
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/deserializer_buf.sv
// Double-buffered serial-to-parallel converter with data_ready/ack handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   INIT    | single cycle after reset, strobes dropped and flagged
//   RECEIVE | accepting bits into the shift unit
//   STALL   | complete word parked in sh, holding register still full
module deserializer_buf
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_100KHZ,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic             status_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             overrun_out
);

  state_t           state, state_next;
  logic             accept;
  logic             last_bit;
  logic             word_done;
  logic             load_direct;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sh_q;

  assign accept      = write_in & status_out;
  assign word_done   = accept & last_bit;
  // The holding register takes the new word whenever it is free or being freed
  // on this same edge, which is what allows back-to-back words with no bubble.
  assign load_direct = word_done & (~data_ready | ack_in);

  deser_shift_unit #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock_100KHZ (clock_100KHZ),
    .reset        (reset),
    .shift_en     (accept),
    .data_in      (data_in),
    .word         (word),
    .sh_q         (sh_q),
    .last_bit     (last_bit)
  );

  // State register.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Next-state decode; status_out depends only on the registered state.
  always_comb begin
    state_next = state;
    status_out = 1'b0;
    case (state)
      INIT: begin
        state_next = RECEIVE;
      end
      RECEIVE: begin
        status_out = 1'b1;
        if (word_done && !load_direct) state_next = STALL;
      end
      STALL: begin
        if (ack_in) state_next = RECEIVE;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Holding register and handshake flag.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_ready <= 1'b0;
    end else if (load_direct) begin
      data_out   <= word;
      data_ready <= 1'b1;
    end else if (state == STALL && ack_in) begin
      data_out   <= sh_q;
    end else if (ack_in && data_ready) begin
      data_ready <= 1'b0;
    end
  end

  // One-cycle flag for a strobe that arrived while bits were not being taken.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) overrun_out <= 1'b0;
    else       overrun_out <= write_in & ~status_out;
  end

endmodule

// File: tb/tb_deserializer_buf.sv
`timescale 1ns/1ps
module tb_deserializer_buf;

  logic clock_100KHZ = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic write_in = 1'b0;
  logic ack_in = 1'b0;

  always #5 clock_100KHZ = ~clock_100KHZ;

  // Three instances share the stimulus: 8-bit MSB-first, 8-bit LSB-first, 12-bit MSB-first.
  logic [7:0]  do0, do1;
  logic [11:0] do2;
  logic        st[3], rdy[3], ovr[3];
  logic [15:0] dout[3];

  assign dout[0] = {8'h00, do0};
  assign dout[1] = {8'h00, do1};
  assign dout[2] = {4'h0, do2};

  deserializer_buf #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clock_100KHZ(clock_100KHZ), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .status_out(st[0]), .data_out(do0), .data_ready(rdy[0]), .overrun_out(ovr[0]));
  deserializer_buf #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clock_100KHZ(clock_100KHZ), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .status_out(st[1]), .data_out(do1), .data_ready(rdy[1]), .overrun_out(ovr[1]));
  deserializer_buf #(.WIDTH(12), .MSB_FIRST(1'b1)) dut2 (
    .clock_100KHZ(clock_100KHZ), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .status_out(st[2]), .data_out(do2), .data_ready(rdy[2]), .overrun_out(ovr[2]));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Behavioural model: words are built by bit position, buffers as plain slots.
  int          mw[3] = '{8, 8, 12};
  bit          mm[3] = '{1'b1, 1'b0, 1'b1};
  logic        m_init[3], m_ready[3], m_stv[3], m_ovr[3];
  logic [15:0] m_held[3], m_stall[3], m_acc[3];
  int          m_cnt[3];

  // Advance the model on each edge using the inputs seen at that edge.
  always @(posedge clock_100KHZ or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_init[i] = 1'b1; m_ready[i] = 1'b0; m_stv[i] = 1'b0; m_ovr[i] = 1'b0;
        m_held[i] = '0; m_stall[i] = '0; m_acc[i] = '0; m_cnt[i] = 0;
      end else begin
        automatic logic taking = !m_init[i] && !m_stv[i];
        automatic logic xfer = 1'b0;
        automatic int pos;
        m_ovr[i] = write_in && !taking;
        if (m_init[i]) begin
          m_init[i] = 1'b0;
        end else if (m_stv[i]) begin
          if (ack_in) begin
            m_held[i] = m_stall[i];
            m_stv[i] = 1'b0;
          end
        end else begin
          if (write_in) begin
            pos = mm[i] ? (mw[i] - 1 - m_cnt[i]) : m_cnt[i];
            m_acc[i][pos] = data_in;
            m_cnt[i]++;
            if (m_cnt[i] == mw[i]) begin
              if (!m_ready[i] || ack_in) begin
                m_held[i] = m_acc[i]; m_ready[i] = 1'b1; xfer = 1'b1;
              end else begin
                m_stall[i] = m_acc[i]; m_stv[i] = 1'b1;
              end
              m_acc[i] = '0;
              m_cnt[i] = 0;
            end
          end
          if (!xfer && ack_in) m_ready[i] = 1'b0;
        end
      end
    end
  end

  // Compare every instance against the model mid-cycle.
  always @(negedge clock_100KHZ) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        check("cyc_status", i, {15'd0, st[i]}, {15'd0, !m_init[i] && !m_stv[i]});
        check("cyc_ready", i, {15'd0, rdy[i]}, {15'd0, m_ready[i]});
        check("cyc_data", i, dout[i], m_held[i]);
        check("cyc_overrun", i, {15'd0, ovr[i]}, {15'd0, m_ovr[i]});
      end
    end
  end

  task automatic step(input logic d, input logic w, input logic a);
    data_in = d; write_in = w; ack_in = a;
    @(posedge clock_100KHZ); #1;
    write_in = 1'b0; ack_in = 1'b0;
  endtask

  // Reset, check cleared outputs while held, release, and consume the INIT cycle.
  task automatic do_reset();
    write_in = 1'b0; ack_in = 1'b0;
    reset = 1'b1;
    @(posedge clock_100KHZ); #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_status", i, {15'd0, st[i]}, 16'd0);
      check("rst_ready", i, {15'd0, rdy[i]}, 16'd0);
      check("rst_data", i, dout[i], 16'd0);
      check("rst_overrun", i, {15'd0, ovr[i]}, 16'd0);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Sends the n bits of v, most significant first, with optional random idle gaps.
  task automatic send_bits(input logic [15:0] v, input int n, input logic ack_last, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        automatic int g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step(1'b0, 1'b0, 1'b0);
      end
      step(v[n-1-k], 1'b1, (k == n - 1) ? ack_last : 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock_100KHZ);
    #1;
    do_reset();

    // Pattern 1,0,1,0,0,1,0,1: palindromic, so both bit orders give 0xA5.
    send_bits(16'h00A5, 8, 1'b0, 1'b0);
    check("a5_msb_data", 0, dout[0], 16'h00A5);
    check("a5_msb_ready", 0, {15'd0, rdy[0]}, 16'd1);
    check("a5_lsb_data", 1, dout[1], 16'h00A5);
    check("a5_model", 0, m_held[0], 16'h00A5);
    step(1'b0, 1'b0, 1'b1);
    check("a5_ack_ready", 0, {15'd0, rdy[0]}, 16'd0);
    check("a5_ack_data", 0, dout[0], 16'h00A5);

    // Pattern 1,1,0,0,0,0,0,0.
    send_bits(16'h00C0, 8, 1'b0, 1'b0);
    check("c0_lsb_data", 1, dout[1], 16'h0003);
    check("c0_msb_data", 0, dout[0], 16'h00C0);
    check("c0_lsb_model", 1, m_held[1], 16'h0003);
    step(1'b0, 1'b0, 1'b1);

    // Two words with no ack: second parks, extra strobe overruns.
    do_reset();
    send_bits(16'h003C, 8, 1'b0, 1'b0);
    send_bits(16'h00C3, 8, 1'b0, 1'b0);
    check("stall_status", 0, {15'd0, st[0]}, 16'd0);
    check("stall_data", 0, dout[0], 16'h003C);
    check("stall_ready", 0, {15'd0, rdy[0]}, 16'd1);
    step(1'b1, 1'b1, 1'b0);
    check("stall_overrun", 0, {15'd0, ovr[0]}, 16'd1);
    step(1'b0, 1'b0, 1'b1);
    check("stall_ovr_clear", 0, {15'd0, ovr[0]}, 16'd0);
    check("stall_ack_data", 0, dout[0], 16'h00C3);
    check("stall_ack_ready", 0, {15'd0, rdy[0]}, 16'd1);
    check("stall_ack_status", 0, {15'd0, st[0]}, 16'd1);
    step(1'b0, 1'b0, 1'b1);
    check("stall_drain", 0, {15'd0, rdy[0]}, 16'd0);

    // Ack coinciding with the last bit of the second word: direct transfer.
    do_reset();
    send_bits(16'h0011, 8, 1'b0, 1'b0);
    send_bits(16'h0022, 8, 1'b1, 1'b0);
    check("same_edge_data", 0, dout[0], 16'h0022);
    check("same_edge_ready", 0, {15'd0, rdy[0]}, 16'd1);
    check("same_edge_status", 0, {15'd0, st[0]}, 16'd1);
    check("same_edge_overrun", 0, {15'd0, ovr[0]}, 16'd0);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-word leaves no residue.
    do_reset();
    send_bits(16'h0015, 5, 1'b0, 1'b0);
    do_reset();
    send_bits(16'h00FF, 8, 1'b0, 1'b0);
    check("post_rst_data", 0, dout[0], 16'h00FF);
    check("post_rst_lsb", 1, dout[1], 16'h00FF);

    // 12-bit word with random idle gaps.
    do_reset();
    send_bits(16'h0ABC, 12, 1'b0, 1'b1);
    check("w12_data", 2, dout[2], 16'h0ABC);
    check("w12_ready", 2, {15'd0, rdy[2]}, 16'd1);

    // Randomised traffic checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
      end
    end

    @(negedge clock_100KHZ);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
